// File: rtl/ram_arbiter_pkg.sv
// cpu_types_pkg: shared CPU types used by the RAM arbiter slice.
//   word_t       - 32-bit machine word
//   ramstate_t   - state reported by the unified RAM port
//   arb_state_t  - arbiter grant state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the fetch, data and RAM-side signals of the arbiter.
//   modport slave  - the arbiter's view (requests and RAM status in, waits,
//                    loads and RAM strobes out)
//   modport master - the surrounding pipeline/RAM view (mirror of slave)
interface ram_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arb_starve_cnt.sv
// ram_arb_starve_cnt: counts data grants taken while a fetch is waiting.
//   CLK, nRST - clock and asynchronous active-low reset
//   incEn     - a data grant was decided while iREN was high
//   clrEn     - a fetch grant was decided
//   atLimit   - count has reached STARVE_LIMIT; next decision favours fetch
// Only instantiated when RAM_ARB_STARVE_GUARD_EN is defined.
module ram_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic incEn,
  input  logic clrEn,
  output logic atLimit
);

  logic [2:0] count_r;

  // Saturating grant counter; a clear has priority over an increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_r <= 3'd0;
    end else if (clrEn) begin
      count_r <= 3'd0;
    end else if (incEn && (count_r != 3'd7)) begin
      count_r <= count_r + 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign atLimit = (count_r == 3'(STARVE_LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single RAM port between instruction fetch and the
// data (MEM stage) requester. Data has priority; a grant is held until RAM
// reports ACCESS, and every access passes through one IDLE decision cycle.
//   CLK     - system clock, rising edge
//   nRST    - asynchronous active-low reset
//   bus     - ram_arbiter_if.slave: fetch/data requests, waits and loads,
//             RAM strobes/address/store data, RAM load data and status
//   arb_err - one-cycle pulse when RAM reports ERROR during a grant
// Optional: define RAM_ARB_STARVE_GUARD_EN to let a waiting fetch win after
// STARVE_LIMIT consecutive data grants.
module ram_arbiter
  import cpu_types_pkg::*;
`ifdef RAM_ARB_STARVE_GUARD_EN
#(
  parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
  input  logic         CLK,
  input  logic         nRST,
  ram_arbiter_if.slave bus,
  output logic         arb_err
);

  arb_state_t arbState_r;
  arb_state_t nextState_s;
  logic       dReq_s;
  logic       starveForce_s;

  assign dReq_s = bus.dREN | bus.dWEN;

`ifdef RAM_ARB_STARVE_GUARD_EN
  logic starveInc_s;
  logic starveClr_s;

  assign starveInc_s = (arbState_r == IDLE) && (nextState_s == DSERV) && bus.iREN;
  assign starveClr_s = (arbState_r == IDLE) && (nextState_s == ISERV);

  ram_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uStarveCnt (
    .CLK    (CLK),
    .nRST   (nRST),
    .incEn  (starveInc_s),
    .clrEn  (starveClr_s),
    .atLimit(starveForce_s)
  );
`else
  assign starveForce_s = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      arbState_r <= IDLE;
    end else begin
      arbState_r <= nextState_s;
    end
  end

  // Next-state decision; a withdrawn request or a completed access ends the grant.
  always_comb begin
    nextState_s = arbState_r;
    case (arbState_r)
      IDLE: begin
        if (dReq_s && !(starveForce_s && bus.iREN)) begin
          nextState_s = DSERV;
        end else if (bus.iREN) begin
          nextState_s = ISERV;
        end else begin
          nextState_s = IDLE;
        end
      end
      DSERV: begin
        if (!dReq_s || (bus.ramstate == ACCESS)) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = DSERV;
        end
      end
      ISERV: begin
        if (!bus.iREN || (bus.ramstate == ACCESS)) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = ISERV;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // RAM-side drive; strobes are gated by the live request so a withdrawal
  // drops them in the same cycle. Write wins when both data strobes are high.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    case (arbState_r)
      DSERV: begin
        bus.ramaddr  = bus.daddr;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramstore = bus.dstore;
      end
      ISERV: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
      end
      default: begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0000_0000;
        bus.ramstore = 32'h0000_0000;
      end
    endcase
  end

  assign bus.dwait = dReq_s & ~((arbState_r == DSERV) && (bus.ramstate == ACCESS));
  assign bus.iwait = bus.iREN & ~((arbState_r == ISERV) && (bus.ramstate == ACCESS));
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign arb_err   = (arbState_r != IDLE) && (bus.ramstate == ERROR);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized bench for ram_arbiter. A RAM model
// answers the DUT, a reference memory predicts load data, and a monitor
// compares every completion against the scoreboard queues.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int STARVE_EXP = 4;
`else
  localparam int STARVE_EXP = 8;
`endif

  typedef struct packed {
    logic  isW;
    word_t addr;
    word_t data;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  logic arb_err;
  int   compared = 0;
  int   mismatched = 0;

  exp_t  iQ[$];
  exp_t  dQ[$];
  exp_t  monE;
  word_t refMem [256];
  word_t ramMem [256];
  bit    ramWr  [256];
  logic [7:0] ramIdx;

  ram_arbiter_if bus();

  always #5 CLK = ~CLK;

  ram_arbiter dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .arb_err(arb_err)
  );

  function automatic word_t initVal(input int idx);
    return (word_t'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // RAM model: combinational read data, write committed on ACCESS
  assign ramIdx = bus.ramaddr[9:2];
  assign bus.ramload = ramWr[ramIdx] ? ramMem[ramIdx] : initVal(int'(ramIdx));
  always @(posedge CLK) begin
    if (bus.ramWEN && bus.ramstate == ACCESS) begin
      ramMem[ramIdx] <= bus.ramstore;
      ramWr[ramIdx]  <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushD(input logic isW, input word_t addr, input word_t data);
    if (isW) begin
      refMem[addr[9:2]] = data;
      dQ.push_back({1'b1, addr, data});
    end else begin
      dQ.push_back({1'b0, addr, refMem[addr[9:2]]});
    end
  endtask

  task automatic pushI(input word_t addr);
    iQ.push_back({1'b0, addr, refMem[addr[9:2]]});
  endtask

  // Monitor: checks reset outputs, idle strobes and pops on every completion
  always @(negedge CLK) begin
    #2;
    check("strobe_excl", 32'(bus.ramREN & bus.ramWEN), 32'd0);
    if (!nRST) begin
      check("rst_ram_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
      check("rst_ramaddr", bus.ramaddr, 32'd0);
      check("rst_ramstore", bus.ramstore, 32'd0);
      check("rst_arb_err", 32'(arb_err), 32'd0);
    end else begin
      if (!bus.iREN && !bus.dREN && !bus.dWEN)
        check("idle_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
      if (bus.iREN && !bus.iwait) begin
        if (iQ.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL i_spurious: fetch completion at 0x%08h, none expected", bus.ramaddr);
        end else begin
          monE = iQ.pop_front();
          check("i_addr", bus.ramaddr, monE.addr);
          check("i_ren", 32'(bus.ramREN), 32'd1);
          check("i_wen", 32'(bus.ramWEN), 32'd0);
          check("i_load", bus.iload, monE.data);
        end
      end
      if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
        if (dQ.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL d_spurious: data completion at 0x%08h, none expected", bus.ramaddr);
        end else begin
          monE = dQ.pop_front();
          check("d_addr", bus.ramaddr, monE.addr);
          if (monE.isW) begin
            check("d_wen", 32'(bus.ramWEN), 32'd1);
            check("d_ren", 32'(bus.ramREN), 32'd0);
            check("d_store", bus.ramstore, monE.data);
          end else begin
            check("d_ren", 32'(bus.ramREN), 32'd1);
            check("d_load", bus.dload, monE.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit iDone, dDone, iPend, dPend, iServed, stuck;
    int errCnt, stableCnt, dIssued, dDoneCnt, dAtI, iAge, dAge, r, op;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'd0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'd0; bus.dstore = 32'd0; bus.ramstate = FREE;

    // Reset with a pending data read, then release
    @(negedge CLK);
    bus.dREN = 1'b1; bus.daddr = 32'h40; bus.ramstate = ACCESS; pushD(1'b0, 32'h40, 32'd0);
    #3 check("rst_dwait", 32'(bus.dwait), 32'd1);
    @(negedge CLK); nRST = 1'b1;
    #3 check("rel_idle_ren", 32'(bus.ramREN), 32'd0);
    @(negedge CLK);
    #3 check("rel_dserv_ren", 32'(bus.ramREN), 32'd1);
    check("rel_dserv_addr", bus.ramaddr, 32'h40);
    @(negedge CLK); bus.dREN = 1'b0; bus.ramstate = FREE;

    // Write 0xDEADBEEF to 0x40
    @(negedge CLK);
    bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'hDEADBEEF; bus.ramstate = ACCESS;
    pushD(1'b1, 32'h40, 32'hDEADBEEF);
    #3 check("wr_c1_dwait", 32'(bus.dwait), 32'd1);
    @(negedge CLK);
    #3 check("wr_c2_wen", 32'(bus.ramWEN), 32'd1);
    check("wr_c2_dwait", 32'(bus.dwait), 32'd0);
    @(negedge CLK); bus.dWEN = 1'b0; bus.ramstate = FREE;

    // Read it back: wait low in cycle 2, IDLE in cycle 3
    @(negedge CLK);
    bus.dREN = 1'b1; bus.daddr = 32'h40; bus.ramstate = ACCESS; pushD(1'b0, 32'h40, 32'd0);
    #3 check("rd_c1_dwait", 32'(bus.dwait), 32'd1);
    @(negedge CLK);
    #3 check("rd_c2_dwait", 32'(bus.dwait), 32'd0);
    check("rd_c2_dload", bus.dload, 32'hDEADBEEF);
    @(negedge CLK);
    #3 check("rd_c3_idle_dwait", 32'(bus.dwait), 32'd1);
    check("rd_c3_idle_ren", 32'(bus.ramREN), 32'd0);
    @(negedge CLK); bus.dREN = 1'b0; bus.ramstate = FREE;
    #3 check("rd_c4_withdrawn_ren", 32'(bus.ramREN), 32'd0);

    // Simultaneous fetch and data write: data first
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h200; pushI(32'h200);
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678; bus.ramstate = ACCESS;
    pushD(1'b1, 32'h80, 32'h12345678);
    #3 check("sim_c1_iwait", 32'(bus.iwait), 32'd1);
    check("sim_c1_dwait", 32'(bus.dwait), 32'd1);
    @(negedge CLK);
    #3 check("sim_c2_wen", 32'(bus.ramWEN), 32'd1);
    check("sim_c2_addr", bus.ramaddr, 32'h80);
    check("sim_c2_iwait", 32'(bus.iwait), 32'd1);
    @(negedge CLK); bus.dWEN = 1'b0;
    #3 check("sim_c3_iwait", 32'(bus.iwait), 32'd1);
    check("sim_c3_ren", 32'(bus.ramREN), 32'd0);
    @(negedge CLK);
    #3 check("sim_c4_addr", bus.ramaddr, 32'h200);
    check("sim_c4_iwait", 32'(bus.iwait), 32'd0);
    @(negedge CLK); bus.iREN = 1'b0; bus.ramstate = FREE;

    // RAM latency and error: ERROR in IDLE, 3 BUSY, ERROR, ACCESS
    @(negedge CLK);
    bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = ERROR; pushD(1'b0, 32'h80, 32'd0);
    #3 check("err_idle_ignored", 32'(arb_err), 32'd0);
    errCnt = 0; stableCnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      bus.ramstate = (k < 3) ? BUSY : ((k == 3) ? ERROR : ACCESS);
      #3;
      errCnt += int'(arb_err);
      if (bus.ramREN && !bus.ramWEN && bus.ramaddr == 32'h80) stableCnt++;
      check((k < 4) ? "err_dwait_held" : "err_dwait_done", 32'(bus.dwait), (k < 4) ? 32'd1 : 32'd0);
    end
    check("err_pulses", 32'(errCnt), 32'd1);
    check("err_strobes_stable", 32'(stableCnt), 32'd5);
    @(negedge CLK); bus.dREN = 1'b0; bus.ramstate = FREE;

    // Flush: fetch withdrawn while BUSY
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h204; bus.ramstate = BUSY; pushI(32'h204);
    @(negedge CLK);
    #3 check("fl_c2_ren", 32'(bus.ramREN), 32'd1);
    check("fl_c2_iwait", 32'(bus.iwait), 32'd1);
    @(negedge CLK); bus.iREN = 1'b0; bus.ramstate = ACCESS; iQ.delete();
    #3 check("fl_c3_ren", 32'(bus.ramREN), 32'd0);
    @(negedge CLK); bus.iREN = 1'b1; pushI(32'h204);
    #3 check("fl_c4_idle_ren", 32'(bus.ramREN), 32'd0);
    check("fl_c4_iwait", 32'(bus.iwait), 32'd1);
    @(negedge CLK);
    #3 check("fl_c5_iwait", 32'(bus.iwait), 32'd0);
    @(negedge CLK); bus.iREN = 1'b0; bus.ramstate = FREE;

    // Starvation: held fetch against a stream of 8 data reads
    dIssued = 0; dDone = 1'b1; iDone = 1'b0; iServed = 1'b0; dDoneCnt = 0; dAtI = -1;
    for (int c = 0; c < 80 && !(iServed && !bus.dREN && !bus.iREN); c++) begin
      @(negedge CLK);
      bus.ramstate = ACCESS;
      if (c == 0) begin bus.iREN = 1'b1; bus.iaddr = 32'h208; pushI(32'h208); end
      if (iDone) bus.iREN = 1'b0;
      if (dDone) begin
        if (dIssued < 8) begin
          bus.dREN = 1'b1; bus.daddr = 32'h100 + 32'(4 * dIssued);
          pushD(1'b0, bus.daddr, 32'd0); dIssued++;
        end else begin
          bus.dREN = 1'b0;
        end
      end
      #3;
      dDone = bus.dREN && !bus.dwait;
      iDone = bus.iREN && !bus.iwait;
      if (dDone) dDoneCnt++;
      if (iDone) begin iServed = 1'b1; dAtI = dDoneCnt; end
    end
    check("starve_fetch_served", 32'(iServed), 32'd1);
    check("starve_data_before_fetch", 32'(dAtI), 32'(STARVE_EXP));
    @(negedge CLK); bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;

    // Randomized traffic followed by a drain with RAM always ready
    iPend = 1'b0; dPend = 1'b0; iDone = 1'b0; dDone = 1'b0; iAge = 0; dAge = 0; stuck = 1'b0;
    for (int c = 0; c < 2100 && !stuck && !(c >= 2000 && !iPend && !dPend); c++) begin
      @(negedge CLK);
      if (iPend && iDone) begin
        iPend = 1'b0; bus.iREN = 1'b0;
      end else if (iPend && $urandom_range(0, 24) == 0) begin
        iPend = 1'b0; bus.iREN = 1'b0; iQ.delete();
      end
      if (!iPend && c < 2000 && $urandom_range(0, 1) == 1) begin
        bus.iaddr = 32'h200 + 32'(4 * $urandom_range(0, 127));
        pushI(bus.iaddr); bus.iREN = 1'b1; iPend = 1'b1; iAge = 0;
      end
      if (dPend && dDone) begin
        dPend = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end
      if (!dPend && c < 2000 && $urandom_range(0, 1) == 1) begin
        op = int'($urandom_range(0, 2));
        bus.daddr = 32'(4 * $urandom_range(0, 127));
        bus.dstore = $urandom;
        bus.dREN = (op != 1); bus.dWEN = (op != 0);
        pushD(bus.dWEN, bus.daddr, bus.dstore); dPend = 1'b1; dAge = 0;
      end
      r = int'($urandom_range(0, 19));
      if (c >= 2000) bus.ramstate = ACCESS;
      else bus.ramstate = (r < 12) ? ACCESS : ((r < 16) ? BUSY : ((r < 18) ? ERROR : FREE));
      #3;
      iDone = iPend && bus.iREN && !bus.iwait;
      dDone = dPend && (bus.dREN || bus.dWEN) && !bus.dwait;
      if (iPend) iAge++;
      if (dPend) dAge++;
      if (iAge > 300 || dAge > 300) begin
        compared++; mismatched++; stuck = 1'b1;
        $display("FAIL rand_timeout: request pending too long (fetch age %0d, data age %0d)", iAge, dAge);
      end
    end
    @(negedge CLK); bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
    #3;
    check("drain_fetch_queue", 32'(iQ.size()), 32'd0);
    check("drain_data_queue", 32'(dQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
